// File: rtl/interval_cnt_tracker.sv
// Per-lane interval counters with sticky exit status and a valid/ready exit-event channel.
// New beats stall only while an exit event is pending and downstream is not taking it.
module interval_cnt_tracker #(
    parameter int unsigned PARALLEL_SIZE = 12,
    parameter int unsigned PARA          = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                valid_i,
    output logic                                ready_o,
    input  logic [PARALLEL_SIZE-1:0]            out_of_mode_interval_i,
    input  logic [PARALLEL_SIZE-1:0]            lane_clear_i,
    input  logic [PARA-1:0]                     patience_i,
    output logic [PARALLEL_SIZE-1:0][PARA-1:0]  interval_cnt_o,
    output logic [PARALLEL_SIZE-1:0]            exited_o,
    output logic                                exit_valid_o,
    input  logic                                exit_ready_i,
    output logic [PARALLEL_SIZE-1:0]            exit_mask_o
);

    localparam logic [PARA-1:0] CntMax = '1;

    logic [PARALLEL_SIZE-1:0][PARA-1:0] cnt_q, cnt_d, cnt_inc;
    logic [PARALLEL_SIZE-1:0]           exited_q, exited_d;
    logic [PARALLEL_SIZE-1:0]           exit_mask_q, exit_mask_d;
    logic [PARALLEL_SIZE-1:0]           new_exit;
    logic                               exit_valid_q, exit_valid_d;
    logic                               accept;

    assign ready_o = !exit_valid_q || exit_ready_i;
    assign accept  = valid_i && ready_o;

    always_comb begin
        cnt_d       = cnt_q;
        exited_d    = exited_q;
        cnt_inc     = cnt_q;
        new_exit    = '0;
        exit_valid_d = exit_valid_q;
        exit_mask_d  = exit_mask_q;

        for (int unsigned i = 0; i < PARALLEL_SIZE; i++) begin
            cnt_inc[i] = (cnt_q[i] == CntMax) ? cnt_q[i] : cnt_q[i] + PARA'(1);
            if (accept) begin
                if (lane_clear_i[i]) begin
                    cnt_d[i]    = '0;
                    exited_d[i] = 1'b0;
                end else if (exited_q[i]) begin
                    cnt_d[i]    = cnt_q[i];
                end else if (out_of_mode_interval_i[i]) begin
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_inc[i];
                    // Zero patience disables exits entirely.
                    if ((patience_i != '0) && (cnt_inc[i] >= patience_i)) begin
                        new_exit[i] = 1'b1;
                        exited_d[i] = 1'b1;
                    end
                end
            end
        end

        // An accepted beat always replaces the event: either it was empty or it is being consumed.
        if (accept) begin
            exit_valid_d = |new_exit;
            exit_mask_d  = new_exit;
        end else if (exit_valid_q && exit_ready_i) begin
            exit_valid_d = 1'b0;
            exit_mask_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            exited_q     <= '0;
            exit_valid_q <= 1'b0;
            exit_mask_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            exited_q     <= exited_d;
            exit_valid_q <= exit_valid_d;
            exit_mask_q  <= exit_mask_d;
        end
    end

    assign interval_cnt_o = cnt_q;
    assign exited_o       = exited_q;
    assign exit_valid_o   = exit_valid_q;
    assign exit_mask_o    = exit_mask_q;

endmodule

// File: doc/interval_cnt_tracker.md
INTERVAL_CNT_TRACKER -- requirements
Module: interval_cnt_tracker

Interface
REQ-001 SHALL have parameters: PARALLEL_SIZE, default 12, number of lanes; PARA, default 16, counter width in bits.
REQ-002 SHALL use one clock and a synchronous, active-high reset; ports are listed below, clock and reset first.
REQ-003 clk_i  input  1  clock, all state updates on the rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 valid_i  input  1  a result beat from the comparison stage is present.
REQ-006 ready_o  output  1  tracker accepts the beat this cycle.
REQ-007 out_of_mode_interval_i  input  PARALLEL_SIZE  per-lane flag: 1 = score left the mode interval.
REQ-008 lane_clear_i  input  PARALLEL_SIZE  per-lane new-token start; qualified by valid_i && ready_o.
REQ-009 patience_i  input  PARA  exit threshold, unsigned; sampled on each accepted beat.
REQ-010 interval_cnt_o  output  PARALLEL_SIZE x PARA  registered per-lane counters, returned to the comparison stage.
REQ-011 exited_o  output  PARALLEL_SIZE  registered sticky per-lane exit status.
REQ-012 exit_valid_o  output  1  an exit event is pending.
REQ-013 exit_ready_i  input  1  downstream accepts the exit event.
REQ-014 exit_mask_o  output  PARALLEL_SIZE  lanes that newly exited in the pending event; valid only while exit_valid_o is 1.

Function
REQ-015 Accept condition: valid_i && ready_o; no state SHALL change on non-accepted cycles except exit-event clearing (REQ-024).
REQ-016 ready_o SHALL be combinational: ready_o = !exit_valid_o || exit_ready_i.
REQ-017 Per lane, on accept, priority order:
- 1) lane_clear_i=1: counter <= 0, exited <= 0.
- 2) else if exited=1: hold counter and exited.
- 3) else if flag=1: counter <= 0.
- 4) else (flag=0): counter <= counter+1, saturating at 2^PARA-1 with no wrap-around.
REQ-018 New exit, per lane: on accept, rule 4 applies, patience_i != 0, and the incremented (saturated) counter >= patience_i; the lane's exited bit SHALL then be set on the next edge.
REQ-019 patience_i = 0 SHALL disable exit; counters still count and saturate.
REQ-020 Latency: interval_cnt_o and exited_o SHALL reflect an accepted beat exactly one cycle after acceptance.
REQ-021 interval_cnt_o and exited_o SHALL be driven directly from registers.
REQ-022 If an accepted beat produces at least one new exit, exit_valid_o SHALL be 1 on the next cycle, with exit_mask_o = the set of newly exited lanes.
REQ-023 exit_valid_o and exit_mask_o SHALL hold stable until exit_valid_o && exit_ready_i.
REQ-024 On an exit handshake with no simultaneous new exit, exit_valid_o SHALL clear to 0 and exit_mask_o to 0 on the next edge.
REQ-025 Handshake and new beat in the same cycle: that beat is accepted (per REQ-016), and the registers SHALL update as follows:
- exit_valid_o = 1 if that beat yields new exits, else 0;
- exit_mask_o = that beat's new exits only.
REQ-026 A lane cleared and exiting in the same beat is impossible by priority: clear wins, and the lane SHALL NOT appear in exit_mask_o.
REQ-027 Clearing a lane SHALL NOT alter a pending exit_mask_o.
REQ-028 With no exit pending, ready_o SHALL be 1 regardless of exit_ready_i.

Reset
REQ-029 rst_i=1 SHALL set, on the next edge, all of the following to 0: interval_cnt_o, exited_o, exit_valid_o, exit_mask_o.
REQ-030 Reset SHALL override any simultaneous beat or handshake.
REQ-031 Reset asserted mid-operation (event pending, counters nonzero) SHALL discard the pending event.
REQ-032 ready_o SHALL be 1 in the cycle after reset is released.

Verification
REQ-033 Patience 3, lane 0 flags 0,0,0 on consecutive beats -> cnt0 = 1,2,3; exit_valid_o=1 and exit_mask_o=12'h001 one cycle after the 3rd beat; exited_o[0]=1.
REQ-034 Patience 4, lane 5 flags 0,0,1,0 -> cnt5 = 1,2,0,1; no exit event.
REQ-035 Exit pending and exit_ready_i=0 -> ready_o=0; valid_i held 3 cycles -> counters unchanged; exit_ready_i=1 -> beat accepted that cycle.
REQ-036 Patience 0, lane 2 cnt=16'hFFFE, flag 0 twice -> cnt = FFFF, FFFF; never exits.
REQ-037 Lane 1 exited; beat with lane_clear_i[1]=1 -> cnt1=0, exited_o[1]=0; next flag 0 -> cnt1=1.
REQ-038 Event pending with cnt0=2; rst_i=1 for one cycle -> all outputs 0 and ready_o=1 afterwards.
